// File: rtl/pwm_dac_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_dac_pkg
// Purpose  : Shared types and constants for the PWM audio DAC.
//            - state_t    : controller state (IDLE / RUN)
//            - DATA_W_DEFAULT : default sample width
//            - midscale() : half-scale duty value (the "silent" level)
// Revision : 1.0 - initial release
// ============================================================================
package pwm_dac_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DATA_W_DEFAULT = 8;

    // Duty value that gives a 50 % waveform, i.e. zero after AC coupling.
    function automatic int midscale(input int width);
        return 1 << (width - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sample_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sample_fifo
// Purpose  : Synchronous FIFO with registered full/empty flags and an
//            occupancy output. Read data is the current head (show-ahead).
// Ports    : clk, rst_n (async active-low)
//            push / wdata : write when push && !full
//            pop  / rdata : remove head when pop && !empty
//            full, empty  : registered status flags
//            level        : current occupancy, 0..DEPTH
// Revision : 1.0 - initial release
// ============================================================================
module sample_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic [LW-1:0]    w_level_nxt;
    logic             r_full;
    logic             r_empty;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = push && !r_full;
    assign w_do_pop  = pop && !r_empty;

    always_comb begin
        w_level_nxt = r_level;
        case ({w_do_push, w_do_pop})
            2'b10:   w_level_nxt = r_level + LW'(1);
            2'b01:   w_level_nxt = r_level - LW'(1);
            default: w_level_nxt = r_level;
        endcase
    end

    // Storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == LW'(DEPTH));
            r_empty <= (w_level_nxt == '0);
        end
    end

    assign rdata = r_mem[r_rd_ptr];
    assign full  = r_full;
    assign empty = r_empty;
    assign level = r_level;

endmodule
`default_nettype wire

// File: rtl/pwm_dac.sv
`default_nettype none
// ============================================================================
// Module   : pwm_dac
// Purpose  : Audio sample sink. Buffers unsigned samples in a small FIFO and
//            plays one sample per PWM period (2^DATA_W ticks) as a duty cycle
//            on pwm_out. When starved the previous duty is held.
// Ports    : clk, rst_n (async active-low)
//            en            : run enable (0 = idle, output low)
//            sample_in/_valid/_ready : sample handshake, ready = !full
//            pwm_out       : registered PWM bit
//            underrun      : one-cycle pulse, period boundary found FIFO empty
//            fifo_level    : FIFO occupancy
// Options  : PWM_DAC_MUTE_ON_UNDERRUN_EN - on underrun load midscale instead
//            of holding the last duty.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_dac
    import pwm_dac_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEFAULT,
    parameter int FIFO_DEPTH = 4,
    parameter int PRESCALE   = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [DATA_W-1:0]             sample_in,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    output logic                          pwm_out,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [DATA_W-1:0] c_ctr_max  = '1;
    localparam logic [PRE_W-1:0]  c_pre_last = PRE_W'(PRESCALE - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_first;
    logic [PRE_W-1:0]    r_pre_ctr;
    logic [DATA_W-1:0]   r_pwm_ctr;
    logic [DATA_W-1:0]   r_duty;
    logic                r_pwm;

    logic                w_tick;
    logic                w_boundary;
    logic                w_full;
    logic                w_empty;
    logic [DATA_W-1:0]   w_head;
    logic [DATA_W-1:0]   w_new_duty;
    logic [DATA_W:0]     w_ctr_inc;

    sample_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (sample_valid),
        .wdata (sample_in),
        .pop   (w_boundary),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .level (fifo_level)
    );

    assign w_tick = (r_pre_ctr == c_pre_last);

    // The first RUN cycle forces a boundary so the first sample plays at
    // once instead of waiting a whole period. en=0 suppresses boundaries so
    // nothing is popped on the way back to IDLE.
    assign w_boundary = (r_state == RUN) && en &&
                        (r_first || (w_tick && (r_pwm_ctr == c_ctr_max)));

`ifdef PWM_DAC_MUTE_ON_UNDERRUN_EN
    localparam logic [DATA_W-1:0] c_midscale = DATA_W'(midscale(DATA_W));
    assign w_new_duty = w_empty ? c_midscale : w_head;
`else
    assign w_new_duty = w_empty ? r_duty : w_head;
`endif

    // One bit wider so the max counter value + 1 does not wrap to zero.
    assign w_ctr_inc = {1'b0, r_pwm_ctr} + (DATA_W + 1)'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (en)  w_state_nxt = RUN;
            RUN:  if (!en) w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_first   <= 1'b0;
            r_pre_ctr <= '0;
            r_pwm_ctr <= '0;
            r_duty    <= '0;
            r_pwm     <= 1'b0;
        end else if ((r_state != RUN) || !en) begin
            // Idle, or leaving RUN: silence and park all counters at zero.
            r_first   <= (r_state == IDLE) && en;
            r_pre_ctr <= '0;
            r_pwm_ctr <= '0;
            r_duty    <= '0;
            r_pwm     <= 1'b0;
        end else begin
            r_first   <= 1'b0;
            r_pre_ctr <= w_tick ? '0 : r_pre_ctr + PRE_W'(1);
            if (w_boundary) begin
                r_pwm_ctr <= '0;
                r_duty    <= w_new_duty;
                r_pwm     <= (w_new_duty != '0);
            end else if (w_tick) begin
                r_pwm_ctr <= w_ctr_inc[DATA_W-1:0];
                r_pwm     <= (w_ctr_inc < {1'b0, r_duty});
            end
        end
    end

    assign sample_ready = !w_full;
    assign pwm_out      = r_pwm;
    assign underrun     = w_boundary && w_empty;

endmodule
`default_nettype wire

// File: tb/tb_pwm_dac.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_dac
// Purpose  : Self-checking bench for pwm_dac. A queue-based reference model
//            predicts pwm_out, underrun, sample_ready and fifo_level for the
//            PRESCALE=1 instance; a second PRESCALE=3 instance is checked
//            against hand-derived pulse widths and periods.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_dac;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int MAXC  = 255;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          en;
    logic          sample_valid;
    logic [DW-1:0] sample_in;
    logic          sample_ready;
    logic          pwm_out;
    logic          underrun;
    logic [2:0]    fifo_level;

    logic          en3;
    logic          valid3;
    logic [DW-1:0] sample3;
    logic          ready3;
    logic          pwm3;
    logic          und3;
    logic [2:0]    level3;

    int errors = 0;
    int checks = 0;

    pwm_dac #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .PRESCALE(1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sample_in(sample_in),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .pwm_out(pwm_out), .underrun(underrun), .fifo_level(fifo_level)
    );

    pwm_dac #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .PRESCALE(3)) dut_p3 (
        .clk(clk), .rst_n(rst_n), .en(en3), .sample_in(sample3),
        .sample_valid(valid3), .sample_ready(ready3),
        .pwm_out(pwm3), .underrun(und3), .fifo_level(level3)
    );

    // ---------------- reference model (PRESCALE=1 instance) ----------------
    // m_pos = ticks elapsed since the last period boundary; the output is
    // high while m_pos < duty.
    int m_q[$];
    bit m_run;
    bit m_first;
    int m_pos;
    int m_duty;
    bit m_can_push;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_run   = 1'b0;
            m_first = 1'b0;
            m_pos   = 0;
            m_duty  = 0;
        end else begin
            m_can_push = (m_q.size() < DEPTH);
            if (!m_run) begin
                if (en) begin
                    m_run   = 1'b1;
                    m_first = 1'b1;
                end
            end else if (!en) begin
                m_run   = 1'b0;
                m_first = 1'b0;
                m_pos   = 0;
                m_duty  = 0;
            end else if (m_first || m_pos == MAXC) begin
                m_first = 1'b0;
                m_pos   = 0;
                if (m_q.size() > 0) m_duty = m_q.pop_front();
`ifdef PWM_DAC_MUTE_ON_UNDERRUN_EN
                else m_duty = 1 << (DW - 1);
`endif
            end else begin
                m_pos = m_pos + 1;
            end
            if (sample_valid && m_can_push) m_q.push_back(int'(sample_in));
        end
    end

    function automatic logic [5:0] exp_vec();
        logic pwm_e, und_e, rdy_e;
        pwm_e = (m_pos < m_duty);
        und_e = m_run && en && (m_first || m_pos == MAXC) && (m_q.size() == 0);
        rdy_e = (m_q.size() < DEPTH);
        return {pwm_e, und_e, rdy_e, 3'(m_q.size())};
    endfunction

    function automatic logic [5:0] obs_vec();
        return {pwm_out, underrun, sample_ready, fifo_level};
    endfunction

    task automatic step(input logic v, input logic [DW-1:0] d, input logic e);
        @(negedge clk);
        sample_valid = v;
        sample_in    = d;
        en           = e;
        #1;
    endtask

    task automatic step3(input logic v, input logic [DW-1:0] d, input logic e);
        @(negedge clk);
        valid3  = v;
        sample3 = d;
        en3     = e;
        #1;
    endtask

    // ------------------------------- tests ---------------------------------
    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; sample_valid = 1'b0; sample_in = '0;
        en3 = 1'b0; valid3 = 1'b0; sample3 = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (obs_vec() !== 6'b001000) begin
            errors++; $display("FAIL reset_main got=%b exp=%b", obs_vec(), 6'b001000);
        end
        checks++;
        if ({pwm3, und3, ready3, level3} !== 6'b001000) begin
            errors++; $display("FAIL reset_p3 got=%b exp=%b", {pwm3, und3, ready3, level3}, 6'b001000);
        end
        rst_n = 1'b1;
        step(1'b0, '0, 1'b0);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL reset_release got=%b exp=%b", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_empty_underrun();
        int und_cnt = 0;
        bit pwm_seen = 1'b0;
        for (int s = 1; s <= 600; s++) begin
            step(1'b0, '0, 1'b1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL empty_run step=%0d got=%b exp=%b", s, obs_vec(), exp_vec());
            end
            if (underrun) und_cnt++;
            if (pwm_out) pwm_seen = 1'b1;
        end
        checks++;
        if (und_cnt !== 3) begin
            errors++; $display("FAIL empty_underrun_count got=%0d exp=3", und_cnt);
        end
        checks++;
        if (pwm_seen !== 1'b0) begin
            errors++; $display("FAIL empty_pwm_low got=%b exp=0", pwm_seen);
        end
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
    endtask

    task automatic test_hold_64();
        int hi = 0;
        int und_cnt = 0;
        step(1'b1, 8'd64, 1'b0);
        for (int s = 1; s <= 600; s++) begin
            step(1'b0, '0, 1'b1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL hold64 step=%0d got=%b exp=%b", s, obs_vec(), exp_vec());
            end
            if (pwm_out) hi++;
            if (underrun) und_cnt++;
        end
        // periods start at steps 3, 259, 515: 64 + 64 + 64 high cycles
        checks++;
        if (hi !== 192) begin
            errors++; $display("FAIL hold64_high got=%0d exp=192", hi);
        end
        checks++;
        if (und_cnt !== 2) begin
            errors++; $display("FAIL hold64_underruns got=%0d exp=2", und_cnt);
        end
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int hi [5] = '{0, 0, 0, 0, 0};
        int exp_hi [5];
        int first_und = 0;
        logic [DW-1:0] seq [4] = '{8'd10, 8'd0, 8'd255, 8'd128};
        exp_hi = '{10, 0, 255, 128, 128};
        for (int i = 0; i < 4; i++) step(1'b1, seq[i], 1'b0);
        for (int s = 1; s <= 1290; s++) begin
            step(1'b0, '0, 1'b1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL b2b step=%0d got=%b exp=%b", s, obs_vec(), exp_vec());
            end
            if (s >= 3 && (s - 3) / 256 < 5 && pwm_out) hi[(s - 3) / 256]++;
            if (underrun && first_und == 0) first_und = s;
        end
        for (int p = 0; p < 5; p++) begin
            checks++;
            if (hi[p] !== exp_hi[p]) begin
                errors++; $display("FAIL b2b_period%0d_high got=%0d exp=%0d", p, hi[p], exp_hi[p]);
            end
        end
        checks++;
        if (first_und !== 1026) begin
            errors++; $display("FAIL b2b_first_underrun got=%0d exp=1026", first_und);
        end
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
    endtask

    task automatic test_fill_ready();
        logic rdy2, rdy3;
        for (int s = 1; s <= 6; s++) begin
            step(1'b1, DW'($urandom), 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL fill step=%0d got=%b exp=%b", s, obs_vec(), exp_vec());
            end
        end
        checks++;
        if ({sample_ready, fifo_level} !== 4'b0_100) begin
            errors++; $display("FAIL fill_full got=%b exp=0100", {sample_ready, fifo_level});
        end
        rdy2 = 1'b1;
        rdy3 = 1'b0;
        for (int s = 1; s <= 600; s++) begin
            step(1'b1, DW'($urandom), 1'b1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL fill_run step=%0d got=%b exp=%b", s, obs_vec(), exp_vec());
            end
            if (s == 2) rdy2 = sample_ready;
            if (s == 3) rdy3 = sample_ready;
        end
        checks++;
        if ({rdy2, rdy3} !== 2'b01) begin
            errors++; $display("FAIL fill_ready_rise got=%b exp=01", {rdy2, rdy3});
        end
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
    endtask

    task automatic test_random();
        logic e = 1'b1;
        logic v;
        for (int s = 1; s <= 3000; s++) begin
            if ($urandom_range(0, 399) == 0) e = !e;
            v = ($urandom_range(0, 255) < 2);
            step(v, DW'($urandom), e);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL random step=%0d got=%b exp=%b", s, obs_vec(), exp_vec());
            end
        end
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
    endtask

    task automatic test_prescale3();
        int rises [8];
        int lens  [8];
        int nrise = 0;
        int nlen  = 0;
        int run   = 0;
        logic prev = 1'b0;
        bit und_seen = 1'b0;
        for (int i = 0; i < 4; i++) step3(1'b1, 8'd2, 1'b0);
        for (int s = 1; s <= 2500; s++) begin
            step3(1'b0, '0, 1'b1);
            if (pwm3 && !prev && nrise < 8) begin
                rises[nrise] = s;
                nrise++;
            end
            if (pwm3) run++;
            if (!pwm3 && prev && nlen < 8) begin
                lens[nlen] = run;
                nlen++;
                run = 0;
            end
            if (und3) und_seen = 1'b1;
            prev = pwm3;
        end
        checks++;
        if (nrise !== 4) begin
            errors++; $display("FAIL p3_rise_count got=%0d exp=4", nrise);
        end else begin
            checks++;
            if (rises[1] - rises[0] !== 767) begin
                errors++; $display("FAIL p3_first_period got=%0d exp=767", rises[1] - rises[0]);
            end
            checks++;
            if (rises[2] - rises[1] !== 768) begin
                errors++; $display("FAIL p3_period got=%0d exp=768", rises[2] - rises[1]);
            end
            checks++;
            if (rises[3] - rises[2] !== 768) begin
                errors++; $display("FAIL p3_period2 got=%0d exp=768", rises[3] - rises[2]);
            end
        end
        checks++;
        if (nlen < 3 || lens[0] !== 5 || lens[1] !== 6 || lens[2] !== 6) begin
            errors++; $display("FAIL p3_high_time got=%0d,%0d,%0d exp=5,6,6", lens[0], lens[1], lens[2]);
        end
        checks++;
        if (und_seen !== 1'b0) begin
            errors++; $display("FAIL p3_underrun got=%b exp=0", und_seen);
        end
        step3(1'b0, '0, 1'b0);
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] seq [4] = '{8'd200, 8'd1, 8'd2, 8'd3};
        bit und2 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b1, seq[i], 1'b0);
        for (int s = 1; s <= 40; s++) begin
            step(1'b0, '0, 1'b1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL rstmid_pre step=%0d got=%b exp=%b", s, obs_vec(), exp_vec());
            end
        end
        #2;
        checks++;
        if ({pwm_out, fifo_level} !== 4'b1_011) begin
            errors++; $display("FAIL rstmid_setup got=%b exp=1011", {pwm_out, fifo_level});
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs_vec() !== 6'b001000) begin
            errors++; $display("FAIL rstmid_async got=%b exp=%b", obs_vec(), 6'b001000);
        end
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        rst_n = 1'b1;
        for (int s = 1; s <= 20; s++) begin
            step(1'b0, '0, 1'b0);
            checks++;
            if (obs_vec() !== 6'b001000) begin
                errors++; $display("FAIL rstmid_idle step=%0d got=%b exp=%b", s, obs_vec(), 6'b001000);
            end
        end
        for (int s = 1; s <= 4; s++) begin
            step(1'b0, '0, 1'b1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL rstmid_restart step=%0d got=%b exp=%b", s, obs_vec(), exp_vec());
            end
            if (s == 2) und2 = underrun;
        end
        checks++;
        if (und2 !== 1'b1) begin
            errors++; $display("FAIL rstmid_first_underrun got=%b exp=1", und2);
        end
        step(1'b0, '0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_empty_underrun();
        test_hold_64();
        test_back_to_back();
        test_fill_ready();
        test_random();
        test_prescale3();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pwm_dac.md
Name: pwm_dac

Overview:
- Sink end of the audio sample stream: accepts unsigned samples from a waveform generator (triangle, square, etc.) over a valid/ready handshake.
- Buffers samples in a small FIFO and converts each one to a pulse-width-modulated output bit that drives the speaker pin.
- Consumes exactly one sample per PWM period and holds the last duty cycle when starved.

Parameters:
- DATA_W, 8, sample width; PWM period = 2^DATA_W ticks.
- FIFO_DEPTH, 4, sample FIFO entries; power of two, >= 2.
- PRESCALE, 1, clocks per PWM tick; >= 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  run enable; 0 = idle/silent.
- sample_in  in  DATA_W  unsigned sample (duty value).
- sample_valid  in  1  sample_in is valid.
- sample_ready  out  1  FIFO can accept; equals !full, driven only from registers.
- pwm_out  out  1  registered PWM bit.
- underrun  out  1  one-cycle pulse: period boundary found the FIFO empty.
- fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async assert, sync release):
  - pwm_out=0, underrun=0, FIFO empty, fifo_level=0, sample_ready=1.
  - duty=0, pwm_ctr=0, pre_ctr=0, state IDLE.
- Push: a sample is written when sample_valid && sample_ready at a rising edge. Push is accepted in both IDLE and RUN.
- Simultaneous push and pop: level is unchanged. At full, sample_ready=0, so no push occurs in that cycle even if a pop happens.
- Tick: tick=1 when pre_ctr==PRESCALE-1, and pre_ctr then wraps to 0. With PRESCALE=1, tick=1 on every cycle.
- States:
  - IDLE: pwm_out=0; pwm_ctr, pre_ctr and duty held at 0; no pops. en=1 moves to RUN on the next edge.
  - RUN: on the first cycle after entry a boundary is forced (load step below), regardless of tick.
  - RUN with en=0: moves to IDLE on the next edge; pwm_out=0 that edge and counters clear. The FIFO contents are retained.
- Boundary (tick && pwm_ctr==2^DATA_W-1, or the forced entry boundary):
  - pwm_ctr<=0.
  - If the FIFO is non-empty: pop, duty<=head.
  - If the FIFO is empty: duty unchanged and underrun pulses high for exactly that cycle.
  - pwm_out<=(new_duty!=0).
- Non-boundary tick: pwm_ctr<=pwm_ctr+1; pwm_out<=(pwm_ctr+1 < duty).
- Non-tick cycle: all state is held.
- High time per period is duty ticks. duty=0 gives constant low. duty=2^DATA_W-1 gives high for all but 1 tick.
- Latency: a sample pushed into an empty FIFO in RUN takes effect at the next boundary. pwm_out reflects the new duty on the boundary edge itself.
- Comparison is unsigned at DATA_W bits. pwm_ctr+1 is computed at DATA_W+1 bits so it does not wrap.
- Reset mid-period: immediate return to reset values; any partial period is discarded.

Optional Feature:
- Macro: PWM_DAC_MUTE_ON_UNDERRUN_EN.
- Defined: on an underrun boundary, duty<=2^(DATA_W-1) (midscale, silence), and underrun still pulses.
- Undefined: the last duty is held, as specified above.
- Ports are identical in both builds.

Decomposition:
- Package pwm_dac_pkg holds:
  - state enum {IDLE, RUN};
  - default DATA_W constant;
  - localparam function for the midscale value.
- Sub-module sample_fifo: synchronous FIFO with registered full/empty and a level output, parameterised by width and depth. pwm_dac instantiates it once.

Test Plan:
- Reset, then en=1 with the FIFO empty (DATA_W=8, PRESCALE=1) -> underrun pulses on the first RUN cycle and on every 256th cycle after it; pwm_out stays 0.
- Push 64 then en=1 -> pwm_out high for 64 cycles, low for 192; level returns to 0; one underrun at the next boundary; the 64/192 pattern repeats with the held duty.
- Push 0, 255, 128 back to back -> three periods with high times of 0, 255 and 128 ticks; no underrun until the fourth boundary. With PWM_DAC_MUTE_ON_UNDERRUN_EN the fourth period has 128 high ticks; without it, the fourth period has 128 high ticks via hold (verify by pushing 10 first, giving 10 vs 128).
- Keep sample_valid high with en=0 -> 4 samples accepted, then sample_ready=0 and fifo_level=4. After en=1, one pop per period; sample_ready rises the cycle after the first pop.
- PRESCALE=3, push 2 -> pwm_out high for 6 cycles per 768-cycle period.
- Assert rst_n=0 mid-period with pwm_out=1 and 3 samples queued -> pwm_out=0, level=0 and sample_ready=1 immediately (asynchronous); after release, the block idles until en=1.
